mem_stage: RTL and testbench

- Memory stage of the Beta pipeline, directly downstream of execute.
- Latches pc/ir/y/st from execute and performs LD/ST/LDR accesses on a variable-latency data-memory req/ack port.
- Stalls upstream while an access is outstanding and drives pc/ir/writeback-data toward the writeback stage.
- Owns bus-safe annulment (drain) and access timeout.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_if.sv | 16 +
 rtl/mem_stage_access_fsm.sv | 74 +++++++
 rtl/mem_stage.sv | 100 ++++++++++
 tb/tb_mem_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the Beta memory stage: opcodes, IR source
// encodings, canned instructions and the access FSM state type.
package mem_stage_pkg;

  localparam logic [5:0] OPCODE_LD  = 6'h18;
  localparam logic [5:0] OPCODE_ST  = 6'h19;
  localparam logic [5:0] OPCODE_JMP = 6'h1B;
  localparam logic [5:0] OPCODE_BEQ = 6'h1C;
  localparam logic [5:0] OPCODE_BNE = 6'h1D;
  localparam logic [5:0] OPCODE_LDR = 6'h1F;

  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  // ADD(R31, R31, R31)
  localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
  // BNE(R31, 0, XP): links the faulting PC into XP
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_BUSY  = 2'd1,
    MEM_DRAIN = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage.
// Handshake: req acts as valid. Once req rises, addr/we/wdata stay stable
// and req stays high until the cycle in which ack is seen (ack acts as
// ready and marks rdata valid in that same cycle). The only exception is
// an access timeout, where the stage drops req without an ack.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_access_fsm.sv
// Access sequencer for the memory stage: tracks an outstanding request,
// counts wait cycles, generates req/stall and flags a timeout.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_op,
  input  logic       live,
  input  logic       ack,
  output logic       req,
  output logic       stall,
  output logic       timeout,
  output mem_state_t state
);

  mem_state_t state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       at_limit;

  assign at_limit = (wait_cnt == 8'(MAX_WAIT));

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MEM_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Next state, request, stall and timeout generation
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    req        = 1'b0;
    stall      = 1'b0;
    timeout    = 1'b0;
    case (state)
      MEM_IDLE: begin
        req   = mem_op;
        stall = mem_op & ~ack;
        if (mem_op && !ack) begin
          state_next = MEM_BUSY;
          wait_next  = 8'd0;
        end
      end
      MEM_BUSY, MEM_DRAIN: begin
        if (at_limit) begin
          // request is abandoned; no ack can be owed any more
          timeout    = 1'b1;
          state_next = MEM_IDLE;
          wait_next  = 8'd0;
        end else begin
          req = 1'b1;
          if (ack) begin
            state_next = MEM_IDLE;
          end else begin
            stall     = 1'b1;
            wait_next = wait_cnt + 8'd1;
            if (state == MEM_BUSY && !live) state_next = MEM_DRAIN;
          end
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Beta memory stage: pipeline registers from execute, LD/ST/LDR accesses
// on the data-memory port, and the writeback-side output muxing.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   ir_src_mem,
  input  logic [31:0]  pc_mem_next,
  input  logic [31:0]  ir_mem_next,
  input  logic [31:0]  y_mem_next,
  input  logic [31:0]  st_mem_next,
  output logic         stall_mem,
  mem_stage_if.master  dmem,
  output logic         mem_err,
  output logic [31:0]  pc_wb_next,
  output logic [31:0]  ir_wb_next,
  output logic [31:0]  y_wb_next,
  output logic [31:0]  bypass_mem
);

  logic [31:0] pc_mem, ir_mem, y_mem, st_mem;
  logic [5:0]  opcode;
  logic        is_ld, is_st, is_ldr, is_load, is_link;
  logic        live, mem_op;
  logic        req, stall, timeout;
  mem_state_t  state;

  assign opcode  = ir_mem[31:26];
  assign is_ld   = (opcode == OPCODE_LD);
  assign is_st   = (opcode == OPCODE_ST);
  assign is_ldr  = (opcode == OPCODE_LDR);
  assign is_load = is_ld | is_ldr;
  assign is_link = (opcode == OPCODE_JMP) | (opcode == OPCODE_BEQ) | (opcode == OPCODE_BNE);
  assign live    = (ir_src_mem == IR_SRC_DATA);
  assign mem_op  = live & (is_load | is_st);

  mem_access_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_op  (mem_op),
    .live    (live),
    .ack     (dmem.ack),
    .req     (req),
    .stall   (stall),
    .timeout (timeout),
    .state   (state)
  );

  // addr/wdata/we come straight from the frozen registers, so they stay
  // stable for as long as the request is outstanding
  assign dmem.req   = req;
  assign dmem.we    = is_st;
  assign dmem.addr  = {y_mem[31:2], 2'b00};
  assign dmem.wdata = st_mem;

  assign stall_mem  = stall;
  assign mem_err    = timeout;
  assign pc_wb_next = pc_mem;
  assign bypass_mem = y_mem;

  // Pipeline registers: load from execute unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mem <= 32'd0;
      ir_mem <= INST_NOP;
      y_mem  <= 32'd0;
      st_mem <= 32'd0;
    end else if (!stall) begin
      pc_mem <= pc_mem_next;
      ir_mem <= ir_mem_next;
      y_mem  <= y_mem_next;
      st_mem <= st_mem_next;
    end
  end

  // Writeback IR and data selection; bubble while the access is pending
  always_comb begin
    ir_wb_next = INST_NOP;
    y_wb_next  = 32'd0;
    if (timeout) begin
      ir_wb_next = INST_BNE_EXCEPT;
      y_wb_next  = pc_mem;
    end else if (!stall) begin
      case (ir_src_mem)
        IR_SRC_DATA:   ir_wb_next = ir_mem;
        IR_SRC_EXCEPT: ir_wb_next = INST_BNE_EXCEPT;
        default:       ir_wb_next = INST_NOP;
      endcase
      if (ir_src_mem == IR_SRC_EXCEPT)           y_wb_next = pc_mem;
      else if (state == MEM_DRAIN || !live)      y_wb_next = 32'd0;
      else if (is_load)                          y_wb_next = dmem.rdata;
      else if (is_link)                          y_wb_next = pc_mem;
      else                                       y_wb_next = y_mem;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream checked against a transaction-level expectation.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MW = 5;
  localparam logic [5:0] OPCODE_ADD = 6'h20;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] y;
    logic [31:0] st;
    logic [31:0] rd;
    int          delay;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ir_src;
  logic [31:0] pc_n, ir_n, y_n, st_n;
  logic        stall, mem_err;
  logic [31:0] pc_wb, ir_wb, y_wb, bypass;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if dmem ();

  mem_stage #(.MAX_WAIT(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_src_mem  (ir_src),
    .pc_mem_next (pc_n),
    .ir_mem_next (ir_n),
    .y_mem_next  (y_n),
    .st_mem_next (st_n),
    .stall_mem   (stall),
    .dmem        (dmem),
    .mem_err     (mem_err),
    .pc_wb_next  (pc_wb),
    .ir_wb_next  (ir_wb),
    .y_wb_next   (y_wb),
    .bypass_mem  (bypass)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic present(input op_t o);
    pc_n = o.pc; ir_n = o.ir; y_n = o.y; st_n = o.st;
  endtask

  task automatic present_junk();
    pc_n = $urandom(); ir_n = $urandom(); y_n = $urandom(); st_n = $urandom();
  endtask

  function automatic op_t mk(input logic [5:0] opc, input logic [31:0] y, input logic [31:0] st);
    op_t o;
    o.pc    = $urandom();
    o.ir    = {opc, 26'($urandom())};
    o.y     = y;
    o.st    = st;
    o.rd    = $urandom();
    o.delay = 0;
    return o;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ir_src = IR_SRC_DATA;
    dmem.ack = 1'b0;
    dmem.rdata = 32'd0;
    present_junk();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ir_src = IR_SRC_DATA;
    dmem.ack = 1'b0;
    dmem.rdata = $urandom();
    present_junk();
    step();
    step();
    settle();
    n_cmp++; if (dmem.req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b want 0", dmem.req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", mem_err); end
    n_cmp++; if (ir_wb !== INST_NOP) begin n_err++; $display("FAIL reset_ir got %h want %h", ir_wb, INST_NOP); end
    n_cmp++; if (pc_wb !== 32'd0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc_wb); end
    n_cmp++; if (y_wb !== 32'd0) begin n_err++; $display("FAIL reset_y got %h want 0", y_wb); end
    n_cmp++; if (bypass !== 32'd0) begin n_err++; $display("FAIL reset_bypass got %h want 0", bypass); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    op_t o, f;
    do_reset();
    o = mk(OPCODE_ADD, 32'h0000_0007, 32'd0);
    f = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(o);
    step();
    present(f);
    settle();
    n_cmp++; if (y_wb !== 32'd7) begin n_err++; $display("FAIL alu_y got %h want 7", y_wb); end
    n_cmp++; if (ir_wb !== o.ir) begin n_err++; $display("FAIL alu_ir got %h want %h", ir_wb, o.ir); end
    n_cmp++; if (dmem.req !== 1'b0) begin n_err++; $display("FAIL alu_req got %0b want 0", dmem.req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got %0b want 0", stall); end
    n_cmp++; if (bypass !== 32'd7) begin n_err++; $display("FAIL alu_bypass got %h want 7", bypass); end
  endtask

  task automatic test_ld_zero_wait();
    op_t o, f;
    do_reset();
    o = mk(OPCODE_LD, 32'h0000_1006, 32'd0);
    f = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(o);
    step();
    dmem.ack = 1'b1;
    dmem.rdata = 32'hDEAD_BEEF;
    present(f);
    settle();
    n_cmp++; if (dmem.addr !== 32'h0000_1004) begin n_err++; $display("FAIL ld0_addr got %h want 00001004", dmem.addr); end
    n_cmp++; if (dmem.req !== 1'b1) begin n_err++; $display("FAIL ld0_req got %0b want 1", dmem.req); end
    n_cmp++; if (dmem.we !== 1'b0) begin n_err++; $display("FAIL ld0_we got %0b want 0", dmem.we); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL ld0_stall got %0b want 0", stall); end
    n_cmp++; if (y_wb !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld0_y got %h want deadbeef", y_wb); end
    n_cmp++; if (ir_wb !== o.ir) begin n_err++; $display("FAIL ld0_ir got %h want %h", ir_wb, o.ir); end
    step();
    dmem.ack = 1'b0;
    settle();
    n_cmp++; if (ir_wb !== f.ir) begin n_err++; $display("FAIL ld0_next_ir got %h want %h", ir_wb, f.ir); end
  endtask

  task automatic test_st_wait();
    op_t o, f;
    do_reset();
    o = mk(OPCODE_ST, 32'h0000_0020, 32'h0000_0055);
    f = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(o);
    step();
    for (int cyc = 0; cyc <= 3; cyc++) begin
      dmem.ack = (cyc == 3);
      dmem.rdata = $urandom();
      if (cyc == 3) present(f); else present_junk();
      settle();
      n_cmp++; if (dmem.req !== 1'b1) begin n_err++; $display("FAIL st_req c%0d got %0b want 1", cyc, dmem.req); end
      n_cmp++; if (dmem.we !== 1'b1) begin n_err++; $display("FAIL st_we c%0d got %0b want 1", cyc, dmem.we); end
      n_cmp++; if (dmem.addr !== 32'h20) begin n_err++; $display("FAIL st_addr c%0d got %h want 20", cyc, dmem.addr); end
      n_cmp++; if (dmem.wdata !== 32'h55) begin n_err++; $display("FAIL st_wdata c%0d got %h want 55", cyc, dmem.wdata); end
      n_cmp++; if (stall !== (cyc < 3)) begin n_err++; $display("FAIL st_stall c%0d got %0b want %0b", cyc, stall, cyc < 3); end
      n_cmp++; if (pc_wb !== o.pc) begin n_err++; $display("FAIL st_pc c%0d got %h want %h", cyc, pc_wb, o.pc); end
      n_cmp++; if (ir_wb !== ((cyc < 3) ? INST_NOP : o.ir)) begin n_err++; $display("FAIL st_ir c%0d got %h", cyc, ir_wb); end
      step();
    end
    dmem.ack = 1'b0;
    settle();
    n_cmp++; if (ir_wb !== f.ir) begin n_err++; $display("FAIL st_next_ir got %h want %h", ir_wb, f.ir); end
    n_cmp++; if (y_wb !== f.y) begin n_err++; $display("FAIL st_next_y got %h want %h", y_wb, f.y); end
  endtask

  task automatic test_drain();
    op_t o, f;
    do_reset();
    o = mk(OPCODE_LD, $urandom(), 32'd0);
    f = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(o);
    step();
    for (int cyc = 0; cyc <= 5; cyc++) begin
      ir_src = (cyc < 2) ? IR_SRC_DATA : IR_SRC_NOP;
      dmem.ack = (cyc == 5);
      dmem.rdata = o.rd;
      if (cyc == 5) present(f); else present_junk();
      settle();
      n_cmp++; if (dmem.req !== 1'b1) begin n_err++; $display("FAIL drain_req c%0d got %0b want 1", cyc, dmem.req); end
      n_cmp++; if (stall !== (cyc < 5)) begin n_err++; $display("FAIL drain_stall c%0d got %0b want %0b", cyc, stall, cyc < 5); end
      n_cmp++; if (ir_wb !== INST_NOP) begin n_err++; $display("FAIL drain_ir c%0d got %h want %h", cyc, ir_wb, INST_NOP); end
      n_cmp++; if (dmem.addr !== {o.y[31:2], 2'b00}) begin n_err++; $display("FAIL drain_addr c%0d got %h", cyc, dmem.addr); end
      step();
    end
    ir_src = IR_SRC_DATA;
    dmem.ack = 1'b0;
    settle();
    n_cmp++; if (dmem.req !== 1'b0) begin n_err++; $display("FAIL drain_after_req got %0b want 0", dmem.req); end
    n_cmp++; if (ir_wb !== f.ir) begin n_err++; $display("FAIL drain_after_ir got %h want %h", ir_wb, f.ir); end
  endtask

  task automatic test_timeout();
    op_t o, f;
    do_reset();
    o = mk(OPCODE_LD, $urandom(), 32'd0);
    f = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(o);
    step();
    for (int cyc = 0; cyc <= MW + 1; cyc++) begin
      dmem.ack = 1'b0;
      dmem.rdata = $urandom();
      if (cyc == MW + 1) present(f); else present_junk();
      settle();
      n_cmp++; if (dmem.req !== (cyc <= MW)) begin n_err++; $display("FAIL tmo_req c%0d got %0b want %0b", cyc, dmem.req, cyc <= MW); end
      n_cmp++; if (stall !== (cyc <= MW)) begin n_err++; $display("FAIL tmo_stall c%0d got %0b want %0b", cyc, stall, cyc <= MW); end
      n_cmp++; if (mem_err !== (cyc == MW + 1)) begin n_err++; $display("FAIL tmo_err c%0d got %0b want %0b", cyc, mem_err, cyc == MW + 1); end
      n_cmp++; if (ir_wb !== ((cyc == MW + 1) ? INST_BNE_EXCEPT : INST_NOP)) begin n_err++; $display("FAIL tmo_ir c%0d got %h", cyc, ir_wb); end
      step();
    end
    settle();
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_after_err got %0b want 0", mem_err); end
    n_cmp++; if (ir_wb !== f.ir) begin n_err++; $display("FAIL tmo_after_ir got %h want %h", ir_wb, f.ir); end
  endtask

  task automatic test_reset_mid();
    op_t o;
    do_reset();
    o = mk(OPCODE_ST, $urandom(), $urandom());
    present(o);
    step();
    for (int cyc = 0; cyc < 3; cyc++) begin
      dmem.ack = 1'b0;
      present_junk();
      if (cyc < 2) step();
    end
    settle();
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rmid_pre_stall got %0b want 1", stall); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem.req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %0b want 0", dmem.req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall got %0b want 0", stall); end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rmid_err got %0b want 0", mem_err); end
    step();
    rst_n = 1'b1;
    settle();
    n_cmp++; if (ir_wb !== INST_NOP) begin n_err++; $display("FAIL rmid_ir got %h want %h", ir_wb, INST_NOP); end
    n_cmp++; if (dmem.req !== 1'b0) begin n_err++; $display("FAIL rmid_after_req got %0b want 0", dmem.req); end
  endtask

  task automatic test_back_to_back();
    op_t seq[4];
    do_reset();
    seq[0] = mk(OPCODE_LD, $urandom(), 32'd0);
    seq[1] = mk(OPCODE_LDR, $urandom(), 32'd0);
    seq[2] = mk(OPCODE_ST, $urandom(), $urandom());
    seq[3] = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(seq[0]);
    step();
    for (int k = 0; k < 3; k++) begin
      dmem.ack = 1'b1;
      dmem.rdata = seq[k].rd;
      present(seq[k + 1]);
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall k%0d got %0b want 0", k, stall); end
      n_cmp++; if (dmem.addr !== {seq[k].y[31:2], 2'b00}) begin n_err++; $display("FAIL b2b_addr k%0d got %h", k, dmem.addr); end
      n_cmp++; if (ir_wb !== seq[k].ir) begin n_err++; $display("FAIL b2b_ir k%0d got %h want %h", k, ir_wb, seq[k].ir); end
      if (k < 2) begin
        n_cmp++; if (y_wb !== seq[k].rd) begin n_err++; $display("FAIL b2b_y k%0d got %h want %h", k, y_wb, seq[k].rd); end
      end
      step();
    end
    dmem.ack = 1'b0;
  endtask

  task automatic test_random();
    op_t         ops[$];
    op_t         c, f;
    logic [5:0]  opcs[8];
    logic [5:0]  opc;
    bit          memop, load, link, fin, tmo;
    int          last;
    logic [31:0] exp_ir, exp_y;
    opcs = '{OPCODE_ADD, OPCODE_LD, OPCODE_ST, OPCODE_LDR, OPCODE_JMP, OPCODE_BEQ, OPCODE_BNE, 6'h21};
    do_reset();
    for (int k = 0; k < 120; k++) begin
      c = mk(opcs[$urandom_range(0, 7)], $urandom(), $urandom());
      c.delay = $urandom_range(0, MW + 1);
      ops.push_back(c);
    end
    f = mk(OPCODE_ADD, $urandom(), 32'd0);
    present(ops[0]);
    step();
    for (int k = 0; k < ops.size(); k++) begin
      c = ops[k];
      opc = c.ir[31:26];
      memop = (opc == OPCODE_LD) || (opc == OPCODE_ST) || (opc == OPCODE_LDR);
      load  = (opc == OPCODE_LD) || (opc == OPCODE_LDR);
      link  = (opc == OPCODE_JMP) || (opc == OPCODE_BEQ) || (opc == OPCODE_BNE);
      last  = !memop ? 0 : ((c.delay <= MW) ? c.delay : MW + 1);
      for (int cyc = 0; cyc <= last; cyc++) begin
        fin = (cyc == last);
        tmo = memop && (c.delay > MW) && fin;
        ir_src = IR_SRC_DATA;
        dmem.ack = memop && (c.delay <= MW) && (cyc == c.delay);
        dmem.rdata = dmem.ack ? c.rd : $urandom();
        if (!fin) present_junk();
        else if (k + 1 < ops.size()) present(ops[k + 1]);
        else present(f);
        settle();
        exp_ir = !fin ? INST_NOP : (tmo ? INST_BNE_EXCEPT : c.ir);
        exp_y  = load ? c.rd : (link ? c.pc : c.y);
        n_cmp++; if (dmem.req !== (memop && !tmo)) begin n_err++; $display("FAIL rnd_req op%0d c%0d got %0b", k, cyc, dmem.req); end
        n_cmp++; if (stall !== !fin) begin n_err++; $display("FAIL rnd_stall op%0d c%0d got %0b want %0b", k, cyc, stall, !fin); end
        n_cmp++; if (mem_err !== tmo) begin n_err++; $display("FAIL rnd_err op%0d c%0d got %0b want %0b", k, cyc, mem_err, tmo); end
        n_cmp++; if (ir_wb !== exp_ir) begin n_err++; $display("FAIL rnd_ir op%0d c%0d got %h want %h", k, cyc, ir_wb, exp_ir); end
        n_cmp++; if (pc_wb !== c.pc) begin n_err++; $display("FAIL rnd_pc op%0d c%0d got %h want %h", k, cyc, pc_wb, c.pc); end
        n_cmp++; if (bypass !== c.y) begin n_err++; $display("FAIL rnd_bypass op%0d c%0d got %h want %h", k, cyc, bypass, c.y); end
        if (memop && !tmo) begin
          n_cmp++; if (dmem.addr !== {c.y[31:2], 2'b00}) begin n_err++; $display("FAIL rnd_addr op%0d c%0d got %h", k, cyc, dmem.addr); end
          n_cmp++; if (dmem.we !== (opc == OPCODE_ST)) begin n_err++; $display("FAIL rnd_we op%0d c%0d got %0b", k, cyc, dmem.we); end
          n_cmp++; if (dmem.wdata !== c.st) begin n_err++; $display("FAIL rnd_wdata op%0d c%0d got %h want %h", k, cyc, dmem.wdata, c.st); end
        end
        if (fin && !tmo) begin
          n_cmp++; if (y_wb !== exp_y) begin n_err++; $display("FAIL rnd_y op%0d got %h want %h", k, y_wb, exp_y); end
        end
        step();
      end
    end
    dmem.ack = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_ld_zero_wait();
    test_st_wait();
    test_drain();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
